// File: rtl/key_event_decoder.sv
// PS/2 set-2 scan-code decoder: turns raw bytes into per-slot held / press / release events.
// Auto-repeat is compiled in only when KEY_EVENT_DECODER_AUTOREPEAT_EN is defined.
module key_event_decoder #(
   parameter int                    NUM_KEYS     = 10,
   parameter logic [NUM_KEYS*9-1:0] KEY_TABLE    = {9'h046, 9'h03E, 9'h03D, 9'h036, 9'h02E,
                                                    9'h025, 9'h026, 9'h01E, 9'h016, 9'h045},
   parameter int                    TIMEOUT_CYC  = 50_000,
   parameter int                    REPEAT_DELAY = 25_000_000,
   parameter int                    REPEAT_RATE  = 5_000_000
) (
   input  logic                CLOCK_50,
   input  logic                reset_n,
   input  logic [7:0]          code_in,
   input  logic                code_valid,
   output logic [NUM_KEYS-1:0] key_held,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_repeat,
   output logic                proto_err
);

   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   if (NUM_KEYS < 1 || NUM_KEYS > 32 || TIMEOUT_CYC < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1)
   begin : g_bad_params
      $error("key_event_decoder: parameter out of range");
   end

   typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

   state_t              r_state;
   logic [TO_W-1:0]     r_to_cnt;
   logic [NUM_KEYS-1:0] r_key_held;
   logic [NUM_KEYS-1:0] r_key_press;
   logic [NUM_KEYS-1:0] r_key_release;
   logic                r_proto_err;

   logic                w_is_e0;
   logic                w_is_f0;
   logic                w_ext;
   logic                w_brk;
   logic                w_data_byte;
   logic [NUM_KEYS-1:0] w_match;
   logic [NUM_KEYS-1:0] w_make;
   logic [NUM_KEYS-1:0] w_break;

   assign w_is_e0     = (code_in == 8'hE0);
   assign w_is_f0     = (code_in == 8'hF0);
   assign w_ext       = (r_state == S_EXT) || (r_state == S_EXT_BRK);
   assign w_brk       = (r_state == S_BRK) || (r_state == S_EXT_BRK);
   assign w_data_byte = code_valid && !w_is_e0 && !w_is_f0;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_match = '0;
      for (int i = 0; i < NUM_KEYS; i++)
         w_match[i] = (code_in == KEY_TABLE[9*i +: 8]) && (KEY_TABLE[9*i+8] == w_ext);
   end

   // Duplicate table entries all update; typematic makes and stray breaks fall out here.
   assign w_make  = w_match & ~r_key_held & {NUM_KEYS{w_data_byte && !w_brk}};
   assign w_break = w_match &  r_key_held & {NUM_KEYS{w_data_byte &&  w_brk}};

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_to_cnt      <= '0;
         r_key_held    <= '0;
         r_key_press   <= '0;
         r_key_release <= '0;
         r_proto_err   <= 1'b0;
      end else begin
         r_key_press   <= w_make;
         r_key_release <= w_break;
         r_key_held    <= (r_key_held | w_make) & ~w_break;
         r_proto_err   <= 1'b0;
         if (code_valid) begin
            r_to_cnt <= '0;
            if (w_is_e0) begin
               r_proto_err <= (r_state != S_IDLE);
               r_state     <= S_EXT;
            end else if (w_is_f0) begin
               // A repeated F0 restarts as a plain break, dropping any E0 seen before it.
               r_proto_err <= w_brk;
               r_state     <= (r_state == S_EXT) ? S_EXT_BRK : S_BRK;
            end else begin
               r_state <= S_IDLE;
            end
         end else if (r_state != S_IDLE) begin
            if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
               r_state     <= S_IDLE;
               r_proto_err <= 1'b1;
               r_to_cnt    <= '0;
            end else begin
               r_to_cnt <= r_to_cnt + 1'b1;
            end
         end
      end
   end

`ifdef KEY_EVENT_DECODER_AUTOREPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int REP_W   = $clog2(REP_MAX + 1);
   localparam int TGT_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

   logic [REP_W-1:0]    r_rep_cnt;
   logic [TGT_W-1:0]    r_rep_tgt;
   logic                r_rep_act;
   logic [NUM_KEYS-1:0] r_key_repeat;
   logic [TGT_W-1:0]    w_new_tgt;

   // Lowest-numbered slot wins when one byte makes several slots at once.
   always_comb begin
      w_new_tgt = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--)
         if (w_make[i]) w_new_tgt = TGT_W'(i);
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_rep_cnt    <= '0;
         r_rep_tgt    <= '0;
         r_rep_act    <= 1'b0;
         r_key_repeat <= '0;
      end else begin
         r_key_repeat <= '0;
         if (|w_make) begin
            r_rep_act <= 1'b1;
            r_rep_tgt <= w_new_tgt;
            r_rep_cnt <= REP_W'(REPEAT_DELAY);
         end else if (r_rep_act) begin
            if (w_break[r_rep_tgt] || !r_key_held[r_rep_tgt]) begin
               r_rep_act <= 1'b0;
               r_rep_cnt <= '0;
            end else if (r_rep_cnt <= REP_W'(1)) begin
               r_key_repeat[r_rep_tgt] <= 1'b1;
               r_rep_cnt               <= REP_W'(REPEAT_RATE);
            end else begin
               r_rep_cnt <= r_rep_cnt - 1'b1;
            end
         end
      end
   end

   assign key_repeat = r_key_repeat;
`else
   assign key_repeat = '0;
`endif

   assign key_held    = r_key_held;
   assign key_press   = r_key_press;
   assign key_release = r_key_release;
   assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: two instances (default table and E0-up-arrow in slot 0)
// checked every cycle against a timestamp-based event model, plus literal spot checks.
module tb_key_event_decoder;

   localparam int NK = 10;
   localparam int TO = 50_000;
   localparam int RD = 100;
   localparam int RR = 20;
   localparam logic [NK*9-1:0] TBL_A = {9'h046, 9'h03E, 9'h03D, 9'h036, 9'h02E,
                                        9'h025, 9'h026, 9'h01E, 9'h016, 9'h045};
   localparam logic [NK*9-1:0] TBL_B = {9'h046, 9'h03E, 9'h03D, 9'h036, 9'h02E,
                                        9'h025, 9'h026, 9'h01E, 9'h016, 9'h175};
`ifdef KEY_EVENT_DECODER_AUTOREPEAT_EN
   localparam logic [31:0] REP3 = 32'h008;
`else
   localparam logic [31:0] REP3 = 32'h000;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    code_in = 8'h00;
   logic          code_valid = 1'b0;
   logic [NK-1:0] a_held, a_press, a_rel, a_rep;
   logic [NK-1:0] b_held, b_press, b_rel, b_rep;
   logic          a_err, b_err;

   int n_vec = 0;
   int n_bad = 0;

   always #10 clk = ~clk;

   key_event_decoder #(.NUM_KEYS(NK), .KEY_TABLE(TBL_A), .TIMEOUT_CYC(TO),
                       .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_a (
      .CLOCK_50(clk), .reset_n(rst_n), .code_in(code_in), .code_valid(code_valid),
      .key_held(a_held), .key_press(a_press), .key_release(a_rel),
      .key_repeat(a_rep), .proto_err(a_err));

   key_event_decoder #(.NUM_KEYS(NK), .KEY_TABLE(TBL_B), .TIMEOUT_CYC(TO),
                       .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_b (
      .CLOCK_50(clk), .reset_n(rst_n), .code_in(code_in), .code_valid(code_valid),
      .key_held(b_held), .key_press(b_press), .key_release(b_rel),
      .key_repeat(b_rep), .proto_err(b_err));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Prefix history is two "seen" flags; timeout and repeat are absolute cycle timestamps.
   longint        cyc = 0;
   bit            m_seen_e0 [2];
   bit            m_seen_f0 [2];
   longint        m_last    [2];
   logic [NK-1:0] m_held    [2];
   logic [NK-1:0] m_press   [2];
   logic [NK-1:0] m_rel     [2];
   logic [NK-1:0] m_rep     [2];
   logic          m_err     [2];
   bit            m_rep_on  [2];
   int            m_tgt     [2];
   longint        m_next    [2];

   function automatic logic [8:0] entry(input int k, input int i);
      return (k == 0) ? TBL_A[9*i +: 9] : TBL_B[9*i +: 9];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_seen_e0[k] = 0; m_seen_f0[k] = 0; m_last[k] = 0;
            m_held[k] = '0; m_press[k] = '0; m_rel[k] = '0; m_rep[k] = '0;
            m_err[k] = 1'b0; m_rep_on[k] = 0; m_tgt[k] = 0; m_next[k] = 0;
         end
      end else begin
         cyc++;
         for (int k = 0; k < 2; k++) begin
            m_press[k] = '0; m_rel[k] = '0; m_rep[k] = '0; m_err[k] = 1'b0;
            if (code_valid) begin
               m_last[k] = cyc;
               if (code_in == 8'hE0) begin
                  m_err[k] = m_seen_e0[k] | m_seen_f0[k];
                  m_seen_e0[k] = 1; m_seen_f0[k] = 0;
               end else if (code_in == 8'hF0) begin
                  m_err[k] = m_seen_f0[k];
                  if (m_seen_f0[k]) m_seen_e0[k] = 0;
                  m_seen_f0[k] = 1;
               end else begin
                  for (int i = 0; i < NK; i++) begin
                     if (entry(k, i) == {m_seen_e0[k], code_in}) begin
                        if (!m_seen_f0[k] && !m_held[k][i]) begin
                           m_held[k][i] = 1'b1; m_press[k][i] = 1'b1;
                        end else if (m_seen_f0[k] && m_held[k][i]) begin
                           m_held[k][i] = 1'b0; m_rel[k][i] = 1'b1;
                        end
                     end
                  end
                  m_seen_e0[k] = 0; m_seen_f0[k] = 0;
               end
            end else if ((m_seen_e0[k] || m_seen_f0[k]) && (cyc - m_last[k] == TO)) begin
               m_err[k] = 1'b1;
               m_seen_e0[k] = 0; m_seen_f0[k] = 0;
            end
`ifdef KEY_EVENT_DECODER_AUTOREPEAT_EN
            if (m_press[k] != '0) begin
               for (int i = NK - 1; i >= 0; i--)
                  if (m_press[k][i]) m_tgt[k] = i;
               m_rep_on[k] = 1;
               m_next[k]   = cyc + RD;
            end else if (m_rep_on[k]) begin
               if (m_rel[k][m_tgt[k]]) begin
                  m_rep_on[k] = 0;
               end else if (cyc == m_next[k]) begin
                  m_rep[k][m_tgt[k]] = 1'b1;
                  m_next[k] = m_next[k] + RR;
               end
            end
`endif
         end
      end
   end

   // Outputs are registered, so the opposite edge sees them settled.
   always @(negedge clk) begin
      check("a_held",  32'(a_held),  32'(m_held[0]));
      check("a_press", 32'(a_press), 32'(m_press[0]));
      check("a_rel",   32'(a_rel),   32'(m_rel[0]));
      check("a_rep",   32'(a_rep),   32'(m_rep[0]));
      check("a_err",   32'(a_err),   32'(m_err[0]));
      check("b_held",  32'(b_held),  32'(m_held[1]));
      check("b_press", 32'(b_press), 32'(m_press[1]));
      check("b_rel",   32'(b_rel),   32'(m_rel[1]));
      check("b_rep",   32'(b_rep),   32'(m_rep[1]));
      check("b_err",   32'(b_err),   32'(m_err[1]));
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      code_in    = b;
      code_valid = 1'b1;
      @(negedge clk);
      code_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      idle(3);
      check("rst_a_held", 32'(a_held), 32'h0);
      check("rst_b_held", 32'(b_held), 32'h0);
      check("rst_a_err",  32'(a_err),  32'h0);
      rst_n = 1'b1;
      idle(2);

      // make / break of slot 1
      send(8'h16);
      check("mk16_press", 32'(a_press), 32'h002);
      check("mk16_held",  32'(a_held),  32'h002);
      send(8'hF0);
      check("f0_held",    32'(a_held),  32'h002);
      check("f0_press",   32'(a_press), 32'h000);
      send(8'h16);
      check("brk16_rel",  32'(a_rel),   32'h002);
      check("brk16_held", 32'(a_held),  32'h000);

      // typematic makes give one press
      send(8'h45);
      check("mk45_press", 32'(a_press), 32'h001);
      send(8'h45);
      check("tm45_press", 32'(a_press), 32'h000);
      send(8'h45);
      check("tm45_held",  32'(a_held),  32'h001);
      check("b_45_held",  32'(b_held),  32'h000);
      send(8'hF0); send(8'h45);
      check("brk45_rel",  32'(a_rel),   32'h001);

      // extended slot in instance b
      send(8'hE0); send(8'h75);
      check("e075_b_press", 32'(b_press), 32'h001);
      check("e075_a_press", 32'(a_press), 32'h000);
      send(8'h75);
      check("bare75_press", 32'(b_press), 32'h000);
      check("bare75_held",  32'(b_held),  32'h001);
      send(8'hE0); send(8'hF0); send(8'h75);
      check("e0f075_rel",   32'(b_rel),   32'h001);
      check("e0f075_held",  32'(b_held),  32'h000);

      // illegal prefixes
      send(8'hE0); send(8'hE0);
      check("e0e0_err",     32'(a_err),   32'h1);
      send(8'h75);
      check("e0e075_press", 32'(b_press), 32'h001);
      send(8'hE0); send(8'hF0); send(8'hE0);
      check("e0f0e0_err",   32'(b_err),   32'h1);
      send(8'h75);
      check("typ_ext_held", 32'(b_held),  32'h001);
      send(8'hE0); send(8'hF0); send(8'h75);
      check("ext_rel",      32'(b_rel),   32'h001);
      send(8'hF0); send(8'hF0);
      check("f0f0_err",     32'(a_err),   32'h1);
      send(8'h1E);
      check("unheld_brk",   32'(a_rel),   32'h000);
      send(8'hE0); send(8'h16);
      check("ext_nomatch",  32'(a_press), 32'h000);

      // two keys down together
      send(8'h25); send(8'h2E);
      check("two_held",     32'(a_held),  32'h030);
      send(8'hF0); send(8'h25);
      check("one_rel",      32'(a_rel),   32'h010);
      check("one_left",     32'(a_held),  32'h020);
      send(8'hF0); send(8'h2E);
      check("none_left",    32'(a_held),  32'h000);

      // prefix timeout
      send(8'hF0);
      idle(TO - 1);
      check("to_early",     32'(a_err),   32'h0);
      idle(1);
      check("to_fire_a",    32'(a_err),   32'h1);
      check("to_fire_b",    32'(b_err),   32'h1);
      idle(1);
      check("to_once",      32'(a_err),   32'h0);
      send(8'h1E);
      check("to_next",      32'(a_press), 32'h004);
      send(8'hF0); send(8'h1E);

      // auto-repeat cadence on slot 3
      send(8'h26);
      check("rep_press",    32'(a_press), 32'h008);
      idle(RD - 1);
      check("rep_pre",      32'(a_rep),   32'h000);
      idle(1);
      check("rep_100",      32'(a_rep),   REP3);
      idle(1);
      check("rep_101",      32'(a_rep),   32'h000);
      idle(RR - 2);
      idle(1);
      check("rep_120",      32'(a_rep),   REP3);
      idle(RR);
      check("rep_140",      32'(a_rep),   REP3);
      send(8'hF0); send(8'h26);
      check("rep_rel",      32'(a_rel),   32'h008);
      idle(3 * RD);

      // reset mid-sequence
      send(8'h16);
      send(8'hF0);
      check("pre_rst_held", 32'(a_held),  32'h002);
      @(negedge clk);
      #5 rst_n = 1'b0;
      #1;
      check("arst_a_held",  32'(a_held),  32'h000);
      check("arst_b_held",  32'(b_held),  32'h000);
      @(negedge clk);
      rst_n = 1'b1;
      send(8'h16);
      check("post_rst_press", 32'(a_press), 32'h002);
      check("post_rst_rel",   32'(a_rel),   32'h000);
      idle(5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
